// File: rtl/ifu_prefetch.sv
// Instruction prefetch queue: runs ahead of the core, one outstanding bus request, redirect flushes.
// Optional performance counters are built when IFU_PREFETCH_PERF_EN is defined.
module ifu_prefetch #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = 'h8000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_ifu_reqValid,
    output logic [XLEN-1:0]          io_ifu_addr,
    input  logic                     io_ifu_respValid,
    input  logic [XLEN-1:0]          io_ifu_rdata,
    output logic                     inst_valid,
    output logic [XLEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_flush_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   inst_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem   [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     count_next;
    logic [XLEN-1:0]   redirect_al;
    logic              push;
    logic              pop;

    assign redirect_al = redirect_pc & ~XLEN'(3);
    assign inst_valid  = (cnt != '0);
    // Redirect wins over both a landing response and a core pop.
    assign push        = (state == REQ) && io_ifu_respValid && !redirect;
    assign pop         = inst_valid && inst_ready && !redirect;

    always_comb begin
        count_next = cnt;
        if (push && !pop)
            count_next = cnt + CW'(1);
        else if (pop && !push)
            count_next = cnt - CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= io_ifu_rdata;
                pc_mem[wr_ptr]   <= fetch_pc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= count_next;
        end
    end

    // The bus address is latched on entry to REQ so DRAIN keeps the old PC while fetch_pc moves on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_al;
                        addr_q   <= redirect_al;
                        state    <= REQ;
                    end else if (cnt < CW'(DEPTH)) begin
                        addr_q <= fetch_pc;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_al;
                        state    <= io_ifu_respValid ? IDLE : DRAIN;
                    end else if (io_ifu_respValid) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                        addr_q   <= fetch_pc + XLEN'(4);
                        state    <= (count_next < CW'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DRAIN: begin
                    if (redirect)
                        fetch_pc <= redirect_al;
                    if (io_ifu_respValid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_ifu_reqValid = (state != IDLE);
    assign io_ifu_addr     = addr_q;
    assign inst            = inst_mem[rd_ptr];
    assign inst_pc         = pc_mem[rd_ptr];
    assign count           = cnt;

`ifdef IFU_PREFETCH_PERF_EN
    logic [31:0] fetch_q;
    logic [31:0] flush_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_q <= '0;
            flush_q <= '0;
        end else begin
            if (push)
                fetch_q <= fetch_q + 32'd1;
            if (redirect)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: fill, streaming, redirect cases, PC wrap and async reset.
module tb_ifu_prefetch;
    localparam int DEPTH = 4;
`ifdef IFU_PREFETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        io_ifu_reqValid;
    logic [31:0] io_ifu_addr;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;

    // Bench-side bus: an automatic responder with fixed latency, or manual strobes.
    logic        auto_en;
    logic        auto_v;
    logic [31:0] auto_data;
    int          lat;
    int          wait_cnt;
    logic        use_nop;
    logic        man_v;
    logic [31:0] man_data;

    int n_asserts;
    int n_fail;
    int exp_fetch;
    int exp_flush;
    int pops;
    int nf;
    logic [31:0] exp_pc;
    logic [31:0] fetched [8];

    ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_ifu_reqValid  (io_ifu_reqValid),
        .io_ifu_addr      (io_ifu_addr),
        .io_ifu_respValid (io_ifu_respValid),
        .io_ifu_rdata     (io_ifu_rdata),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_ready       (inst_ready),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .count            (count),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return use_nop ? 32'h0000_0013 : (a ^ 32'h5A5A_0F0F);
    endfunction

    assign io_ifu_respValid = (auto_v && auto_en) || man_v;
    assign io_ifu_rdata     = man_v ? man_data : auto_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset || !auto_en) begin
            auto_v   <= 1'b0;
            wait_cnt <= 0;
        end else if (auto_v) begin
            auto_v   <= 1'b0;
            wait_cnt <= 0;
        end else if (io_ifu_reqValid) begin
            if (wait_cnt + 1 >= lat) begin
                auto_v    <= 1'b1;
                auto_data <= data_of(io_ifu_addr);
                wait_cnt  <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("no_overflow", 32'(count <= 3'(DEPTH)), 32'd1);
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, "_perf_fetch"}, perf_fetch_cnt, PERF ? 32'(exp_fetch) : 32'd0);
        chk({tag, "_perf_flush"}, perf_flush_cnt, PERF ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        man_v      = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        auto_en    = 1'b0;
        exp_fetch  = 0;
        exp_flush  = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic man_resp(input logic [31:0] d);
        man_v    = 1'b1;
        man_data = d;
        tick();
        man_v    = 1'b0;
    endtask

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        reset       = 1'b1;
        man_v       = 1'b0;
        man_data    = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        auto_en     = 1'b0;
        lat         = 2;
        use_nop     = 1'b1;
        exp_fetch   = 0;
        exp_flush   = 0;
        tick();
        tick();
        chk("rst_reqValid", 32'(io_ifu_reqValid), 32'd0);
        chk("rst_addr", io_ifu_addr, 32'h8000_0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk_perf("rst");

        // Basic fill: 2-cycle bus, core stalled.
        auto_en = 1'b1;
        reset   = 1'b0;
        tick();
        chk("fill_first_req", 32'(io_ifu_reqValid), 32'd1);
        chk("fill_first_addr", io_ifu_addr, 32'h8000_0000);
        nf = 0;
        for (int c = 0; c < 30; c++) begin
            if (io_ifu_respValid && io_ifu_reqValid) begin
                if (nf < 8) fetched[nf] = io_ifu_addr;
                nf++;
                exp_fetch++;
            end
            tick();
        end
        chk("fill_nfetch", 32'(nf), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("fill_addr_seq", fetched[i], 32'h8000_0000 + 32'(4 * i));
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_reqValid_idle", 32'(io_ifu_reqValid), 32'd0);
        chk("fill_head_pc", inst_pc, 32'h8000_0000);
        chk("fill_head_inst", inst, 32'h0000_0013);
        chk("fill_inst_valid", 32'(inst_valid), 32'd1);
        chk_perf("fill");

        // Streaming: redirect to a clean start, 1-cycle bus, core always ready.
        lat         = 1;
        use_nop     = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0000;
        exp_flush++;
        tick();
        redirect = 1'b0;
        chk("stream_flushed", 32'(count), 32'd0);
        exp_pc = 32'h8000_0000;
        pops   = 0;
        for (int c = 0; c < 40; c++) begin
            if (inst_valid) begin
                chk("stream_pc", inst_pc, exp_pc);
                chk("stream_inst", inst, data_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (io_ifu_respValid && io_ifu_reqValid) exp_fetch++;
            tick();
        end
        chk("stream_enough_pops", 32'(pops >= 15), 32'd1);
        chk_perf("stream");

        // Redirect while the request to 0x80000008 is outstanding.
        do_reset();
        tick();
        chk("rif_first_addr", io_ifu_addr, 32'h8000_0000);
        man_resp(32'h0000_0001);
        exp_fetch++;
        man_resp(32'h0000_0002);
        exp_fetch++;
        chk("rif_count2", 32'(count), 32'd2);
        chk("rif_addr8", io_ifu_addr, 32'h8000_0008);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0103;
        exp_flush++;
        tick();
        redirect = 1'b0;
        chk("rif_drain_req", 32'(io_ifu_reqValid), 32'd1);
        chk("rif_drain_addr", io_ifu_addr, 32'h8000_0008);
        chk("rif_flushed", 32'(count), 32'd0);
        chk("rif_flushed_valid", 32'(inst_valid), 32'd0);
        tick();
        tick();
        chk("rif_hold_addr", io_ifu_addr, 32'h8000_0008);
        chk("rif_hold_req", 32'(io_ifu_reqValid), 32'd1);
        man_resp(32'hDEAD_BEEF);
        chk("rif_dropped", 32'(count), 32'd0);
        chk("rif_idle", 32'(io_ifu_reqValid), 32'd0);
        tick();
        chk("rif_new_req", 32'(io_ifu_reqValid), 32'd1);
        chk("rif_new_addr", io_ifu_addr, 32'h8000_0100);
        man_resp(32'h1111_1111);
        exp_fetch++;
        chk("rif_head_pc", inst_pc, 32'h8000_0100);
        chk("rif_head_inst", inst, 32'h1111_1111);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("rif_popped", 32'(count), 32'd0);

        // Redirect + response + pop in the same cycle.
        man_resp(32'h2222_2222);
        exp_fetch++;
        chk("sim_count1", 32'(count), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0200;
        man_v       = 1'b1;
        man_data    = 32'h3333_3333;
        inst_ready  = 1'b1;
        exp_flush++;
        tick();
        redirect   = 1'b0;
        man_v      = 1'b0;
        inst_ready = 1'b0;
        chk("sim_count0", 32'(count), 32'd0);
        chk("sim_valid0", 32'(inst_valid), 32'd0);
        chk("sim_idle", 32'(io_ifu_reqValid), 32'd0);
        tick();
        chk("sim_req", 32'(io_ifu_reqValid), 32'd1);
        chk("sim_addr", io_ifu_addr, 32'h8000_0200);
        chk("sim_count_after", 32'(count), 32'd0);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        man_v       = 1'b1;
        man_data    = 32'h4444_4444;
        exp_flush++;
        tick();
        redirect = 1'b0;
        man_v    = 1'b0;
        chk("wrap_idle", 32'(io_ifu_reqValid), 32'd0);
        tick();
        chk("wrap_addr_top", io_ifu_addr, 32'hFFFF_FFFC);
        man_resp(32'hAAAA_0001);
        exp_fetch++;
        chk("wrap_addr_zero", io_ifu_addr, 32'h0000_0000);
        man_resp(32'hAAAA_0002);
        exp_fetch++;
        chk("wrap_count2", 32'(count), 32'd2);
        chk("wrap_head_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_head_inst", inst, 32'hAAAA_0001);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wrap_count1", 32'(count), 32'd1);
        chk("wrap_next_pc", inst_pc, 32'h0000_0000);
        chk("wrap_next_inst", inst, 32'hAAAA_0002);
        chk_perf("totals");

        // Async reset between edges while a request is pending.
        chk("ar_pre_req", 32'(io_ifu_reqValid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_reqValid", 32'(io_ifu_reqValid), 32'd0);
        chk("ar_addr", io_ifu_addr, 32'h8000_0000);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_inst_valid", 32'(inst_valid), 32'd0);
        chk("ar_inst", inst, 32'd0);
        chk("ar_inst_pc", inst_pc, 32'd0);
        exp_fetch = 0;
        exp_flush = 0;
        chk_perf("ar");
        tick();
        reset    = 1'b0;
        man_v    = 1'b1;
        man_data = 32'h5555_5555;
        tick();
        man_v = 1'b0;
        chk("ar_stale_ignored", 32'(count), 32'd0);
        chk("ar_first_req", 32'(io_ifu_reqValid), 32'd1);
        chk("ar_first_addr", io_ifu_addr, 32'h8000_0000);
        tick();
        chk("ar_still_empty", 32'(count), 32'd0);
        chk_perf("ar_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction-fetch front end between the core and the instruction bus; replaces single-shot fetch.
- Runs ahead of the core and fills a DEPTH-entry instruction/PC queue using the existing reqValid/respValid bus protocol.
- Core pops one instruction per ready cycle.
- Redirect (jump/branch) flushes the queue and cancels the in-flight fetch.

Parameters:
- XLEN, 32, width of addresses and instruction words.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_ifu_reqValid  output  1  bus request; held until respValid.
- io_ifu_addr  output  XLEN  fetch address; stable while reqValid.
- io_ifu_respValid  input  1  one-cycle response strobe.
- io_ifu_rdata  input  XLEN  instruction word, valid with respValid.
- inst_valid  output  1  queue head valid.
- inst  output  XLEN  queue head instruction.
- inst_pc  output  XLEN  queue head PC.
- inst_ready  input  1  core consumes head this cycle.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (forced 0).
- count  output  $clog2(DEPTH)+1  current queue occupancy.
- perf_fetch_cnt  output  32  accepted fetch responses (see optional feature).
- perf_flush_cnt  output  32  redirects taken (see optional feature).

Behaviour:
- Reset values: io_ifu_reqValid=0, io_ifu_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, count=0, fetch_pc=RESET_PC, perf counters=0, state=IDLE.
- Reset may assert at any time, mid-request included. The pending bus response is then dropped: state returns to IDLE, so a late respValid is ignored.

State machine:
- IDLE: if count<DEPTH, go to REQ next edge.
- REQ: reqValid=1 and addr=fetch_pc.
  - On respValid with no redirect: push {fetch_pc, rdata}; fetch_pc+=4 (wraps modulo 2^XLEN); go to REQ if count_next<DEPTH, else IDLE.
- DRAIN: entered when redirect occurs in REQ without respValid. reqValid stays 1 and addr stays at the old PC; the bus is never abandoned. On respValid, discard data and go to IDLE.
- One outstanding request at a time.
- Issue only when count<DEPTH, so a response always has room. Overflow is impossible; assert this in the bench.

Timing:
- First reqValid is high on the first cycle after reset deasserts.
- Response at edge N gives inst_valid=1 at edge N+1 (registered queue, no bypass).
- Pop occurs when inst_valid & inst_ready at the edge. The head advances next cycle.
- Push and pop in the same cycle: count unchanged, order preserved.
- inst_ready with an empty queue is a no-op.

Redirect (highest priority):
- At the edge: queue cleared (count=0, inst_valid=0), fetch_pc=redirect_pc&~3.
- A simultaneous pop is ignored.
- A simultaneous respValid is discarded and not pushed. State goes to IDLE, and the request issues the next cycle.
- Redirect while in DRAIN: update fetch_pc, stay in DRAIN.
- Redirect while IDLE or empty: fetch starts the next cycle at the new PC.

Pointers and count:
- Queue read/write pointers wrap modulo DEPTH.
- count ranges 0..DEPTH.

Optional Feature:
- Macro: IFU_PREFETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on each pushed response.
  - perf_flush_cnt increments on each redirect.
  - Both are 32-bit and wrap at 2^32; both reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
- Basic fill: reset release; memory responds 2 cycles after each reqValid; core holds inst_ready=0 (bus responds 0x00000013). Addresses 0x80000000..0x8000000C are fetched. count reaches 4, then reqValid stays 0 and inst_pc of head = 0x80000000.
- Streaming: inst_ready=1 constantly with 1-cycle bus. inst_pc sequence is 0x80000000, 0x80000004, ... with no gaps or duplicates; inst matches memory contents.
- Redirect in flight: redirect=1 with redirect_pc=0x80000103 while the request to 0x80000008 is outstanding. reqValid stays high at 0x80000008 until respValid; that data is not pushed. The next request goes to 0x80000100 and the first popped inst_pc is 0x80000100.
- Simultaneous redirect + response + pop (redirect_pc=0x80000200): queue empties, the response is dropped, the next addr is 0x80000200, count=0.
- Wrap: redirect_pc=0xFFFFFFFC. Fetches are 0xFFFFFFFC then 0x00000000.
- Async reset mid-request: assert reset between edges while reqValid=1. Outputs return immediately to reset values. A stale respValid after release is ignored and the first fetch is RESET_PC. With IFU_PREFETCH_PERF_EN defined, the counters read 0 after reset and match push/redirect totals after the other tests.
